// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver with 16x oversampling.
// Recovers bytes from the asynchronous RX pin and flags bad stop bits.
module uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter bit MAJORITY    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_16x_tick,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       rx_done_tick,
  output logic       frame_err_tick,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             hist_q;
  logic [3:0]             tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   rx_s;
  logic                   smp;

  // Synchronizer and history reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
      if (baud_16x_tick) hist_q <= {hist_q[1:0], rx_s};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  if (MAJORITY) begin : g_majority
    assign smp = (hist_q[0] & hist_q[1]) | (hist_q[1] & hist_q[2]) | (hist_q[0] & hist_q[2]);
  end else begin : g_single
    assign smp = hist_q[0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch. Pulses default low, so a gap in
    // the tick strobe can never stretch them.
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (baud_16x_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!smp) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == 4'd7) begin
            if (!smp) begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        S_DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d = {smp, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
              tick_d  = '0;
            end
          end
        end
        S_STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            if (smp) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end
        end
        // A held-low break parks here instead of re-framing as repeated 0x00.
        S_WAIT_HIGH: begin
          if (smp) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q != S_IDLE);
    data_out       = data_q;
    rx_done_tick   = done_q;
    frame_err_tick = err_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed and randomized frames against a byte-level expectation queue for uart_rx.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_16x_tick;
  logic       serial_in;
  logic [7:0] data_out;
  logic       rx_done_tick;
  logic       frame_err_tick;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int         err_cnt = 0;
  int         exp_err = 0;
  int         wide_cnt = 0;
  int         both_cnt = 0;
  int         bad_change = 0;
  int         busy_low = 0;
  bit         track_busy = 1'b0;

  logic [1:0] div_q = 2'd0;
  logic       prev_done = 1'b0;
  logic       prev_err = 1'b0;
  logic       prev_rst = 1'b1;
  logic [7:0] prev_data;

  uart_rx #(.SYNC_STAGES(2), .MAJORITY(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_16x_tick  (baud_16x_tick),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .rx_done_tick   (rx_done_tick),
    .frame_err_tick (frame_err_tick),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // One baud tick every 4 clk.
  always @(posedge clk) div_q <= div_q + 2'd1;
  assign baud_16x_tick = (div_q == 2'd3);

  always @(negedge clk) begin
    if (rx_done_tick) got_q.push_back(data_out);
    if (frame_err_tick) err_cnt++;
    if (rx_done_tick && frame_err_tick) both_cnt++;
    if ((rx_done_tick && prev_done) || (frame_err_tick && prev_err)) wide_cnt++;
    if (data_out !== prev_data && !rx_done_tick && !rst && !prev_rst) bad_change++;
    prev_done = rx_done_tick;
    prev_err  = frame_err_tick;
    prev_rst  = rst;
    prev_data = data_out;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic tick_wait();
    @(posedge clk iff baud_16x_tick);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick_wait();
  endtask

  // Transmitter model: 16 ticks per bit, optional 1-tick inverted spike at mid-bit
  // of frame position `spike` (0 = start, 1..8 = data, 9 = stop).
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int spike);
    logic [9:0] fr;
    int         p;
    fr = {stop_v, b, 1'b0};
    for (int bi = 0; bi < 10; bi++) begin
      for (int t = 1; t <= 16; t++) begin
        serial_in = (bi == spike && t == 9) ? ~fr[bi] : fr[bi];
        tick_wait();
        p = 16 * bi + t;
        if (track_busy && p >= 8 && p <= 150 && !busy) busy_low++;
      end
    end
    if (stop_v) begin
      exp_q.push_back(b);
      exp_data = b;
    end else begin
      exp_err++;
    end
  endtask

  initial begin
    logic [9:0] fr;
    rst       = 1'b1;
    serial_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 8'h00);
    check("reset_rx_done", rx_done_tick, 1'b0);
    check("reset_frame_err", frame_err_tick, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    idle(20);

    // Single byte with busy held across the frame.
    busy_low   = 0;
    track_busy = 1'b1;
    send_frame(8'hA5, 1'b1, -1);
    track_busy = 1'b0;
    idle(4);
    check_bytes("t1_byte");
    check("t1_data_out", data_out, exp_data);
    check("t1_frame_err", err_cnt, exp_err);
    check("t1_busy_low_ticks", busy_low, 0);

    // Loopback of random bytes with random short gaps.
    for (int i = 0; i < 8; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, -1);
      idle($urandom_range(0, 5));
    end
    idle(4);
    check_bytes("t2_loopback");

    // Back-to-back with no idle gap.
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    idle(4);
    check_bytes("t2_b2b");
    check("t2_data_out", data_out, 8'h55);

    // Glitch: 4-tick low pulse is rejected at mid start bit.
    serial_in = 1'b0;
    idle(4);
    serial_in = 1'b1;
    idle(3);
    check("t3_busy_in_start", busy, 1'b1);
    idle(6);
    check("t3_busy_back_idle", busy, 1'b0);
    idle(20);
    check_bytes("t3_no_byte");
    check("t3_data_out", data_out, exp_data);
    check("t3_frame_err", err_cnt, exp_err);

    // Framing error followed by a long break, then recovery.
    send_frame(8'h3C, 1'b0, -1);
    check("t4_frame_err", err_cnt, exp_err);
    check("t4_data_out_kept", data_out, 8'h55);
    idle(400);
    check("t4_break_no_err", err_cnt, exp_err);
    check("t4_busy_in_break", busy, 1'b1);
    check_bytes("t4_break_no_byte");
    serial_in = 1'b1;
    idle(24);
    check("t4_busy_after_break", busy, 1'b0);
    send_frame(8'h81, 1'b1, -1);
    idle(4);
    check_bytes("t4_recover");
    check("t4_data_out", data_out, 8'h81);

    // Single-tick spike at mid-bit of data bit 3.
    send_frame(8'hF0, 1'b1, 4);
    idle(4);
    check_bytes("t5_spike");
    check("t5_data_out", data_out, 8'hF0);

    // Reset during bit 4 of 0x96; the sender aborts with it.
    fr = {1'b1, 8'h96, 1'b0};
    for (int bi = 0; bi <= 5; bi++) begin
      serial_in = fr[bi];
      idle((bi == 5) ? 8 : 16);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    serial_in = 1'b1;
    exp_data  = 8'h00;
    check("t6_reset_data_out", data_out, exp_data);
    check("t6_reset_busy", busy, 1'b0);
    idle(40);
    check_bytes("t6_aborted");
    check("t6_frame_err", err_cnt, exp_err);
    send_frame(8'h69, 1'b1, -1);
    idle(4);
    check_bytes("t6_next");
    check("t6_data_out", data_out, 8'h69);

    check("pulse_width", wide_cnt, 0);
    check("pulse_exclusive", both_cnt, 0);
    check("data_out_stable", bad_change, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
